// File: rtl/alu_pkg.sv
// Opcode encodings and default widths shared between the TP1 ALU and its input loader.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debouncer, one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      // The increment that would reach DEBOUNCE_CYCLES flips the level instead, so the count never wraps.
      if (cnt_q >= CNT_LAST) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], i_btn};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign o_press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/alu_input_loader.sv
// Latches board switches into ALU operand A, operand B and opcode on debounced button presses.
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int DATA_W          = ALU_DATA_W,
  parameter int OP_W            = ALU_OP_W,
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [SW_W-1:0]   i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [DATA_W-1:0] o_datoA,
  output logic [DATA_W-1:0] o_datoB,
  output logic [OP_W-1:0]   o_operation,
  output logic [2:0]        o_loaded,
  output logic              o_valid
);

  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] dato_a_q, dato_a_d;
  logic [DATA_W-1:0] dato_b_q, dato_b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [2:0]        loaded_q, loaded_d;
  logic              valid_q;
  logic              load_a, load_b, load_op;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a), .o_press(load_a)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b), .o_press(load_b)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op), .o_press(load_op)
  );

  always_comb begin
    dato_a_d = load_a  ? sw_sync_q[DATA_W-1:0] : dato_a_q;
    dato_b_d = load_b  ? sw_sync_q[DATA_W-1:0] : dato_b_q;
    op_d     = load_op ? sw_sync_q[OP_W-1:0]   : op_q;
    loaded_d = loaded_q | {load_op, load_b, load_a};
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      op_q      <= OP_W'(OP_ADD);
      loaded_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      op_q      <= op_d;
      loaded_q  <= loaded_d;
      valid_q   <= &loaded_d;
    end
  end

  // Switch bits above the operand/opcode widths are synchronized but have no consumer.
  logic unused_sw;
  assign unused_sw = ^sw_sync_q;

  assign o_datoA     = dato_a_q;
  assign o_datoB     = dato_b_q;
  assign o_operation = op_q;
  assign o_loaded    = loaded_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader with a reference model and an expected-state scoreboard.
module tb_alu_input_loader;
  import alu_pkg::*;

  localparam int DATA_W = 4;
  localparam int OP_W   = 6;
  localparam int SW_W   = 8;
  localparam int DEB    = 4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [2:0]        loaded;
    logic              valid;
  } snap_t;

  localparam snap_t RST_SNAP = '{a: 4'h0, b: 4'h0, op: 6'b100000, loaded: 3'b000, valid: 1'b0};

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic [SW_W-1:0]   i_sw;
  logic              i_btn_a, i_btn_b, i_btn_op;
  logic [DATA_W-1:0] o_datoA, o_datoB;
  logic [OP_W-1:0]   o_operation;
  logic [2:0]        o_loaded;
  logic              o_valid;

  int    checks = 0;
  int    errors = 0;
  snap_t model;
  snap_t sb[$];

  alu_input_loader #(
    .DATA_W(DATA_W), .OP_W(OP_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_sw(i_sw),
    .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
    .o_datoA(o_datoA), .o_datoB(o_datoB), .o_operation(o_operation),
    .o_loaded(o_loaded), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input snap_t e);
    check({tag, ".A"},      32'(o_datoA),     32'(e.a));
    check({tag, ".B"},      32'(o_datoB),     32'(e.b));
    check({tag, ".op"},     32'(o_operation), 32'(e.op));
    check({tag, ".loaded"}, 32'(o_loaded),    32'(e.loaded));
    check({tag, ".valid"},  32'(o_valid),     32'(e.valid));
  endtask

  function automatic snap_t apply_load(input snap_t s, input logic [2:0] m, input logic [7:0] sw);
    snap_t r;
    r = s;
    if (m[0]) r.a  = sw[3:0];
    if (m[1]) r.b  = sw[3:0];
    if (m[2]) r.op = sw[5:0];
    r.loaded = s.loaded | m;
    r.valid  = &r.loaded;
    return r;
  endfunction

  task automatic set_btn(input logic [2:0] m);
    {i_btn_op, i_btn_b, i_btn_a} = m;
  endtask

  // Expect nothing through edge DEB+2, then the queued load exactly at edge DEB+3.
  task automatic wait_load(input string tag);
    tick(DEB + 2);
    check_state({tag, ".pre"}, model);
    tick(1);
    check({tag, ".sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) model = sb.pop_front();
    check_state({tag, ".post"}, model);
  endtask

  task automatic press(input string tag, input logic [2:0] m, input logic [7:0] sw);
    i_sw = sw;
    set_btn(m);
    sb.push_back(apply_load(model, m, sw));
    wait_load(tag);
    set_btn(3'b000);
    tick(2 * DEB + 2);
    check_state({tag, ".rel"}, model);
  endtask

  task automatic do_reset(input int n);
    i_rst_n = 1'b0;
    tick(n);
    model = RST_SNAP;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_sw    = 8'h37;
    set_btn(3'b111);
    model = RST_SNAP;

    // 1: reset with buttons held, then each register loads at full latency
    do_reset(2);
    check_state("rst", RST_SNAP);
    sb.push_back(apply_load(model, 3'b111, 8'h37));
    i_rst_n = 1'b1;
    wait_load("rst_held");
    set_btn(3'b000);
    tick(2 * DEB + 2);
    check_state("rst_held.rel", model);

    // 2: full load sequence; valid rises on the opcode load edge
    do_reset(2);
    i_rst_n = 1'b1;
    press("load_a", 3'b001, 8'h05);
    press("load_b", 3'b010, 8'h03);
    press("load_op", 3'b100, 8'h22);
    check("alu_sub", 32'(o_operation == OP_SUB ? o_datoA - o_datoB : 4'hF), 32'd2);

    // 3: bounce shorter than the debounce window is ignored, then one clean press
    do_reset(2);
    i_rst_n = 1'b1;
    i_sw = 8'h0B;
    for (int i = 0; i < 4; i++) begin
      i_btn_a = ~i[0];
      tick(3);
    end
    i_btn_a = 1'b0;
    tick(2 * DEB + 2);
    check_state("bounce", model);
    i_btn_a = 1'b1;
    sb.push_back(apply_load(model, 3'b001, 8'h0B));
    tick(5);
    i_btn_a = 1'b0;
    tick(1);
    check_state("short_hold.pre", model);
    tick(1);
    check("short_hold.sb", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) model = sb.pop_front();
    check_state("short_hold.post", model);
    tick(2 * DEB + 2);
    check_state("short_hold.rel", model);

    // 4: held button loads once; later switch change is not captured
    i_sw = 8'h09;
    i_btn_b = 1'b1;
    sb.push_back(apply_load(model, 3'b010, 8'h09));
    wait_load("held");
    tick(13);
    i_sw = 8'h0C;
    tick(30);
    check_state("held.mid", model);
    i_btn_b = 1'b0;
    tick(2 * DEB + 2);
    check_state("held.rel", model);

    // 5: simultaneous A and B press captures the same switch value
    do_reset(2);
    i_rst_n = 1'b1;
    press("simul", 3'b011, 8'h0A);

    // 6: reset two counts into a debounce discards it; held button reloads afterwards
    i_sw = 8'h25;
    i_btn_op = 1'b1;
    tick(4);
    check_state("mid.pre_rst", model);
    do_reset(2);
    check_state("mid.rst", RST_SNAP);
    sb.push_back(apply_load(model, 3'b100, 8'h25));
    i_rst_n = 1'b1;
    wait_load("mid.reload");
    i_btn_op = 1'b0;
    tick(2 * DEB + 2);
    check_state("mid.rel", model);
    check("sb.empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_input_loader.md
# alu_input_loader

Upstream stage of the TP1 ALU. It takes board switches and three push-buttons, then synchronizes and debounces each button. On each debounced press it latches the switch value into operand A, operand B or the opcode register. Its registered outputs drive the ALU's `i_datoA`, `i_datoB` and `i_operation` directly, so the combinational ALU always sees stable, glitch-free operands.

## Interface
- `DATA_W`, default 4: operand width; must equal the ALU operand width.
- `OP_W`, default 6: opcode width.
- `SW_W`, default 8: switch bank width; must be ≥ max(`DATA_W`, `OP_W`).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change; must be ≥ 2. Benches use 4.

Ports:
- `clk` input, 1: single system clock; all logic is on its rising edge.
- `i_rst_n` input, 1: reset, synchronous and active-low.
- `i_sw` input, `SW_W`: raw switch bank, asynchronous to `clk`.
- `i_btn_a` input, 1: raw button, active-high; loads operand A.
- `i_btn_b` input, 1: raw button, active-high; loads operand B.
- `i_btn_op` input, 1: raw button, active-high; loads the opcode.
- `o_datoA` output, `DATA_W`: operand A register.
- `o_datoB` output, `DATA_W`: operand B register.
- `o_operation` output, `OP_W`: opcode register.
- `o_loaded` output, 3: sticky loaded flags, one per register, `{op, b, a}`.
- `o_valid` output, 1: high when all three `o_loaded` bits are high.

## Operation
- Every raw input (`i_sw` and the three buttons) passes through a 2-FF synchronizer.
- Each button has its own debouncer with these rules:
  - The debouncer holds a debounced level `deb`, reset to 0, and a counter.
  - On any cycle where the synchronized input equals `deb`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `deb` takes the new level and the counter clears.
  - The counter saturates and never wraps.
- Rising-edge detect on `deb` produces a one-cycle `load` pulse.
- Register update on a `load` pulse:
  - `load_a` sets `o_datoA` to `sw_sync[DATA_W-1:0]` and sets `o_loaded[0]`.
  - `load_b` sets `o_datoB` to `sw_sync[DATA_W-1:0]` and sets `o_loaded[1]`.
  - `load_op` sets `o_operation` to `sw_sync[OP_W-1:0]` and sets `o_loaded[2]`.
- Opcode values are not range-checked. Any `OP_W`-bit value is stored and forwarded.
- Falling edges of `deb` have no effect. Holding a button produces exactly one load.
- Simultaneous load pulses are independent: all pulsed registers capture the same `sw_sync` value in the same cycle.
- A reload overwrites the register. `o_loaded` bits stay set until reset.
- Bounce shorter than `DEBOUNCE_CYCLES` never changes `deb` and never produces a load.

## Timing
- Reset values, applied on the first `clk` edge with `i_rst_n`=0:
  - `o_datoA` = 0, `o_datoB` = 0.
  - `o_operation` = `OP_ADD` (6'b100000), so the ALU never sees an undecoded opcode out of reset.
  - `o_loaded` = 0, `o_valid` = 0.
  - All synchronizers, `deb` levels and counters = 0.
- Reset mid-debounce discards partial counts. A button still held after reset release is then re-accepted as a new press after full latency.
- Latency from the first edge sampling a stable-high button to the output register update is `DEBOUNCE_CYCLES` + 3 edges: 2 synchronizer, `DEBOUNCE_CYCLES` counting, 1 for the load register.
- Captured data is `i_sw` as sampled 2 edges before the load edge. Switches must be stable for at least 3 cycles around the press.
- `o_valid` is registered and rises in the same cycle as the last `o_loaded` bit.
- Minimum press/release spacing for two accepted loads is 2·`DEBOUNCE_CYCLES` cycles.

## Structure
- Package `alu_pkg` holds the opcode localparams shared with the ALU: `OP_ADD` 100000, `OP_SUB` 100010, `OP_AND` 100100, `OP_OR` 100101, `OP_XOR` 100110, `OP_SRA` 000011, `OP_SRL` 000010, `OP_NOR` 100111. It also holds the default `DATA_W` and `OP_W`.
- Sub-module `btn_debounce` contains the synchronizer, counter, `deb` register and rising-edge pulse. It is parameterized by `DEBOUNCE_CYCLES` and instantiated three times.
- The top level holds the `i_sw` synchronizer, the three load registers and the flags.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset:** hold `i_rst_n`=0 for 2 cycles with buttons high → A=0, B=0, op=6'b100000, `o_loaded`=000, `o_valid`=0. After release with buttons still high, each register loads after 7 edges.
2. **Full load sequence:**
   - Set `i_sw`=8'h05, press A; then `i_sw`=8'h03, press B; then `i_sw`=8'h22, press op.
   - → A=5, B=3, op=6'b100010, `o_valid`=1 on the op load edge. The downstream ALU shows 2.
3. **Bounce rejection:** toggle `i_btn_a` 1,0,1,0 with pulses of 3 cycles, then release → no change to A, `o_loaded[0]` stays 0. Hold high for 5 cycles → exactly one load after 7 edges.
4. **Held button:** hold `i_btn_b` high for 50 cycles while `i_sw` changes from 8'h09 to 8'h0C at cycle 20 → B=9 only, single load pulse.
5. **Simultaneous press:** `i_sw`=8'h0A, press A and B on the same cycle → A=B=4'hA in the same cycle, `o_loaded`=011.
6. **Reset mid-operation:** assert reset 2 cycles into a press's debounce count → no load occurs, outputs return to reset values. After release, the still-held button loads at full latency.
